// File: rtl/sc_serial_frame_rx_if.sv
// rtl/sc_serial_frame_rx_if.sv - serial line, strobes and received-word outputs of the slow-control receiver
interface sc_serial_frame_rx_if;
    logic        BitEn_i;
    logic        Rx_i;
    logic        resetflags_i;
    logic [31:0] data_ob32;
    logic        newdata_o;
    logic        ParityErr_o;
    logic        FrameErr_o;
    logic        SerialLinkUp_o;
    logic        RxLocked_o;

    modport master (
        output BitEn_i, Rx_i, resetflags_i,
        input  data_ob32, newdata_o, ParityErr_o, FrameErr_o, SerialLinkUp_o, RxLocked_o
    );

    modport slave (
        input  BitEn_i, Rx_i, resetflags_i,
        output data_ob32, newdata_o, ParityErr_o, FrameErr_o, SerialLinkUp_o, RxLocked_o
    );
endinterface

// File: rtl/sc_serial_frame_rx.sv
// rtl/sc_serial_frame_rx.sv - slow-control serial frame receiver with parity/framing checks and link qualification
module sc_serial_frame_rx #(
    parameter int LINKUP_FRAMES = 4,
    parameter int ERR_LIMIT     = 2,
    parameter int TIMEOUT_BITS  = 4096
) (
    input logic                 Clk_ik,
    input logic                 Rst_irn,
    sc_serial_frame_rx_if.slave sc
);
    localparam int GW = $clog2(LINKUP_FRAMES + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LINKUP_FRAMES);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_BITS);

    typedef enum logic [2:0] {HUNT, IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   shreg, shreg_nxt;
    logic [4:0]    bitcnt, bitcnt_nxt;
    logic          par_bit, par_bit_nxt;
    logic [31:0]   data_q;
    logic          newdata_q, parity_err_q, frame_err_q, link_q, link_nxt;
    logic [GW-1:0] goodcnt, goodcnt_nxt;
    logic [EW-1:0] errcnt, errcnt_nxt;
    logic [TW-1:0] tocnt, tocnt_nxt;
    logic          frame_good, frame_bad_par, frame_bad_stop;

    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bitcnt_nxt     = bitcnt;
        par_bit_nxt    = par_bit;
        frame_good     = 1'b0;
        frame_bad_par  = 1'b0;
        frame_bad_stop = 1'b0;
        if (sc.BitEn_i) begin
            case (state)
                HUNT: if (sc.Rx_i) state_nxt = IDLE;
                IDLE: if (!sc.Rx_i) begin
                    state_nxt  = DATA;
                    bitcnt_nxt = 5'd31;
                end
                DATA: begin
                    shreg_nxt = {shreg[30:0], sc.Rx_i};
                    if (bitcnt == 5'd0) state_nxt = PARITY;
                    else bitcnt_nxt = bitcnt - 5'd1;
                end
                PARITY: begin
                    par_bit_nxt = sc.Rx_i;
                    state_nxt   = STOP;
                end
                STOP: begin
                    // A bad stop bit means we may be misaligned, so resynchronise from HUNT
                    if (sc.Rx_i) begin
                        state_nxt = IDLE;
                        if ((^shreg) == par_bit) frame_good = 1'b1;
                        else frame_bad_par = 1'b1;
                    end else begin
                        state_nxt      = HUNT;
                        frame_bad_stop = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        goodcnt_nxt = goodcnt;
        errcnt_nxt  = errcnt;
        tocnt_nxt   = tocnt;
        link_nxt    = link_q;
        if (sc.BitEn_i) begin
            if (frame_good) begin
                tocnt_nxt  = '0;
                errcnt_nxt = '0;
                if (goodcnt < GOOD_MAX) goodcnt_nxt = goodcnt + GW'(1);
                if (goodcnt_nxt == GOOD_MAX) link_nxt = 1'b1;
            end else begin
                if (tocnt < TO_MAX) tocnt_nxt = tocnt + TW'(1);
                if (frame_bad_par || frame_bad_stop) begin
                    goodcnt_nxt = '0;
                    if (errcnt < ERR_MAX) errcnt_nxt = errcnt + EW'(1);
                    if (errcnt_nxt == ERR_MAX) link_nxt = 1'b0;
                end
                // Re-evaluated on every enable while saturated, so the link cannot recover without good frames
                if (tocnt_nxt == TO_MAX) begin
                    link_nxt    = 1'b0;
                    goodcnt_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge Clk_ik or negedge Rst_irn) begin
        if (!Rst_irn) begin
            state        <= HUNT;
            shreg        <= '0;
            bitcnt       <= '0;
            par_bit      <= 1'b0;
            data_q       <= '0;
            newdata_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            link_q       <= 1'b0;
            goodcnt      <= '0;
            errcnt       <= '0;
            tocnt        <= '0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bitcnt    <= bitcnt_nxt;
            par_bit   <= par_bit_nxt;
            newdata_q <= frame_good;
            link_q    <= link_nxt;
            goodcnt   <= goodcnt_nxt;
            errcnt    <= errcnt_nxt;
            tocnt     <= tocnt_nxt;
            if (frame_good) data_q <= shreg;
            if (sc.resetflags_i) begin
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
            end else begin
                if (frame_bad_par) parity_err_q <= 1'b1;
                if (frame_bad_stop) frame_err_q <= 1'b1;
            end
        end
    end

    assign sc.data_ob32      = data_q;
    assign sc.newdata_o      = newdata_q;
    assign sc.ParityErr_o    = parity_err_q;
    assign sc.FrameErr_o     = frame_err_q;
    assign sc.SerialLinkUp_o = link_q;
    assign sc.RxLocked_o     = (state != HUNT);
endmodule
